// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: NUM_CH registered active-low resets, each released after DELAY eligible edges.
// Latency: assertion 1 edge after the cause is sampled; release on the DELAY-th consecutive eligible edge.
// Backpressure: none; in SEQ_MODE each channel waits on the registered release of its predecessor.
module rst_seq_gen #(
    parameter int NUM_CH   = 4,
    parameter int DELAY    = 128,
    parameter int SEQ_MODE = 1
) (
    input  logic              ref_clk_i,
    input  logic              glob_srst_i,
    input  logic [NUM_CH-1:0] arst_req_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              rst_done_o
);

    localparam int CNT_W = $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (NUM_CH < 1 || DELAY < 1) begin : g_param_check
            $error("rst_seq_gen: NUM_CH and DELAY must both be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ASSERTED,
        ST_COUNTING,
        ST_RELEASED
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] rst_q;
    logic [NUM_CH-1:0] rst_d;
    logic [NUM_CH-1:0] prev_ok;
    logic [NUM_CH-1:0] eligible;

    // Sequential mode chains each channel on the registered output of the one below it,
    // so a drop ripples upward one edge per stage and never goes combinational.
    always_comb begin
        prev_ok    = '1;
        for (int i = 1; i < NUM_CH; i++) begin
            if (SEQ_MODE != 0) begin
                prev_ok[i] = rst_q[i-1];
            end
        end
        eligible = ~arst_req_i & prev_ok & {NUM_CH{~glob_srst_i}};
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        rst_d = rst_q;

        for (int i = 0; i < NUM_CH; i++) begin
            if (!eligible[i]) begin
                state_d[i] = ST_ASSERTED;
                cnt_d[i]   = '0;
                rst_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    ST_ASSERTED: begin
                        if (DELAY == 1) begin
                            state_d[i] = ST_RELEASED;
                            rst_d[i]   = 1'b1;
                        end else begin
                            state_d[i] = ST_COUNTING;
                            cnt_d[i]   = CNT_ONE;
                            rst_d[i]   = 1'b0;
                        end
                    end
                    ST_COUNTING: begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = ST_RELEASED;
                            rst_d[i]   = 1'b1;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + CNT_ONE;
                            rst_d[i]   = 1'b0;
                        end
                    end
                    ST_RELEASED: begin
                        state_d[i] = ST_RELEASED;
                        rst_d[i]   = 1'b1;
                    end
                    default: begin
                        state_d[i] = ST_ASSERTED;
                        cnt_d[i]   = '0;
                        rst_d[i]   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge ref_clk_i) begin
        if (glob_srst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_ASSERTED;
                cnt_q[i]   <= '0;
            end
            rst_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rst_q <= rst_d;
        end
    end

    assign rst_n_o    = rst_q;
    assign rst_done_o = &rst_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: three instances (sequential DELAY=4, independent DELAY=4, sequential DELAY=1 with 3 channels).
// Expected output vectors are derived from release-edge timing and queued before each scenario runs.
module tb_rst_seq_gen;

    logic       clk = 1'b0;
    logic       glob_a, glob_b, glob_c;
    logic [3:0] req_a, req_b;
    logic [2:0] req_c;
    logic [3:0] rst_n_a, rst_n_b;
    logic [2:0] rst_n_c;
    logic       done_a, done_b, done_c;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    rst_seq_gen #(.NUM_CH(4), .DELAY(4), .SEQ_MODE(1)) dut_a (
        .ref_clk_i(clk), .glob_srst_i(glob_a), .arst_req_i(req_a),
        .rst_n_o(rst_n_a), .rst_done_o(done_a)
    );
    rst_seq_gen #(.NUM_CH(4), .DELAY(4), .SEQ_MODE(0)) dut_b (
        .ref_clk_i(clk), .glob_srst_i(glob_b), .arst_req_i(req_b),
        .rst_n_o(rst_n_b), .rst_done_o(done_b)
    );
    rst_seq_gen #(.NUM_CH(3), .DELAY(1), .SEQ_MODE(1)) dut_c (
        .ref_clk_i(clk), .glob_srst_i(glob_c), .arst_req_i(req_c),
        .rst_n_o(rst_n_c), .rst_done_o(done_c)
    );

    task automatic test_reset();
        logic [7:0] e, act;
        glob_a = 1'b1; glob_b = 1'b1; glob_c = 1'b1;
        req_a = '0; req_b = '0; req_c = '0;
        for (int n = 0; n < 9; n++) exp_q.push_back(8'h00);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); act = {3'b0, done_a, rst_n_a}; checks++;
            if (act !== e) begin errors++; $display("FAIL reset_a cyc%0d got %b want %b", n, act, e); end
            e = exp_q.pop_front(); act = {3'b0, done_b, rst_n_b}; checks++;
            if (act !== e) begin errors++; $display("FAIL reset_b cyc%0d got %b want %b", n, act, e); end
            e = exp_q.pop_front(); act = {4'b0, done_c, rst_n_c}; checks++;
            if (act !== e) begin errors++; $display("FAIL reset_c cyc%0d got %b want %b", n, act, e); end
        end
    endtask

    // Channel k releases on edge 4*(k+1) after the global reset drops.
    task automatic test_seq_release();
        logic [7:0] e, act;
        logic [3:0] r;
        for (int n = 1; n <= 18; n++) begin
            for (int k = 0; k < 4; k++) r[k] = (n >= 4 * (k + 1));
            exp_q.push_back({3'b0, &r, r});
        end
        glob_a = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); act = {3'b0, done_a, rst_n_a}; checks++;
            if (act !== e) begin errors++; $display("FAIL seq_release edge%0d got %b want %b", n, act, e); end
        end
    endtask

    task automatic test_indep_release();
        logic [7:0] e, act;
        for (int n = 1; n <= 6; n++) exp_q.push_back((n >= 4) ? 8'h1F : 8'h00);
        glob_b = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); act = {3'b0, done_b, rst_n_b}; checks++;
            if (act !== e) begin errors++; $display("FAIL indep_release edge%0d got %b want %b", n, act, e); end
        end
    endtask

    // One-cycle request on channel 1: downstream channels ripple low, then re-release in order.
    task automatic test_req_pulse();
        logic [7:0] e, act;
        logic [3:0] r;
        for (int n = 1; n <= 15; n++) begin
            r[0] = 1'b1;
            r[1] = (n >= 5);
            r[2] = (n < 2) || (n >= 9);
            r[3] = (n < 3) || (n >= 13);
            exp_q.push_back({3'b0, &r, r});
        end
        req_a = 4'b0010;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk); @(negedge clk);
            req_a = 4'b0000;
            e = exp_q.pop_front(); act = {3'b0, done_a, rst_n_a}; checks++;
            if (act !== e) begin errors++; $display("FAIL req_pulse edge%0d got %b want %b", n, act, e); end
        end
    endtask

    // A count aborted after two eligible edges earns no credit: release needs four fresh ones.
    task automatic test_abort_count();
        logic [7:0] e, act;
        exp_q.push_back(8'h00);
        for (int n = 1; n <= 10; n++) exp_q.push_back({7'b0, n >= 7});
        req_a = 4'b0001;
        for (int n = 0; n < 16; n++) begin @(posedge clk); @(negedge clk); end
        e = exp_q.pop_front(); act = {3'b0, done_a, rst_n_a}; checks++;
        if (act !== e) begin errors++; $display("FAIL abort_hold got %b want %b", act, e); end
        req_a = 4'b0000;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); @(negedge clk);
            req_a = (n == 2) ? 4'b0001 : 4'b0000;
            e = exp_q.pop_front(); act = {3'b0, done_a, rst_n_a}; checks++;
            if (act !== e) begin errors++; $display("FAIL abort_count edge%0d got %b want %b", n, act, e); end
        end
    endtask

    // Global reset pulse while channel 2 is counting clears everything and restarts from channel 0.
    task automatic test_glob_mid_seq();
        logic [7:0] e, act;
        logic [3:0] r;
        glob_a = 1'b1;
        for (int n = 0; n < 2; n++) begin @(posedge clk); @(negedge clk); end
        for (int n = 1; n <= 28; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (n <= 9)       r[k] = (n >= 4 * (k + 1));
                else if (n == 10) r[k] = 1'b0;
                else              r[k] = (n >= 14 + 4 * k);
            end
            exp_q.push_back({3'b0, &r, r});
        end
        glob_a = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            @(posedge clk); @(negedge clk);
            glob_a = (n == 9);
            e = exp_q.pop_front(); act = {3'b0, done_a, rst_n_a}; checks++;
            if (act !== e) begin errors++; $display("FAIL glob_mid_seq edge%0d got %b want %b", n, act, e); end
        end
    endtask

    // DELAY=1: one channel per edge after reset, then a single-cycle request ripple on channel 0.
    task automatic test_delay_one();
        logic [7:0] e, act;
        logic [2:0] r;
        for (int n = 1; n <= 5; n++) begin
            for (int k = 0; k < 3; k++) r[k] = (n >= k + 1);
            exp_q.push_back({4'b0, &r, r});
        end
        exp_q.push_back(8'b0000_0110);
        exp_q.push_back(8'b0000_0101);
        exp_q.push_back(8'b0000_0011);
        exp_q.push_back(8'b0000_1111);
        exp_q.push_back(8'b0000_1111);
        glob_c = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front(); act = {4'b0, done_c, rst_n_c}; checks++;
            if (act !== e) begin errors++; $display("FAIL delay_one_rel edge%0d got %b want %b", n, act, e); end
        end
        req_c = 3'b001;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); @(negedge clk);
            req_c = 3'b000;
            e = exp_q.pop_front(); act = {4'b0, done_c, rst_n_c}; checks++;
            if (act !== e) begin errors++; $display("FAIL delay_one_ripple edge%0d got %b want %b", n, act, e); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_seq_release();
        test_indep_release();
        test_req_pulse();
        test_abort_count();
        test_glob_mid_seq();
        test_delay_one();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
